// File: rtl/writeback_manager.sv
// writeback_manager: collects results from NUM_UNITS calculation units through a round-robin
// valid/ready arbiter. It buffers them in a small FIFO and drives the register-file write
// port at one write per cycle. It also exports a mask of registers with a pending write.
// Optional feature: define WB_BYPASS_EN to let a result skip the empty FIFO (0-cycle latency).
module writeback_manager #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NUM_UNITS = 2,
    parameter int unsigned DEPTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_UNITS-1:0]        unit_valid_i,
    output logic [NUM_UNITS-1:0]        unit_ready_o,
    input  logic [NUM_UNITS*XLEN-1:0]   unit_data_i,
    input  logic [NUM_UNITS*5-1:0]      unit_adr_i,
    output logic [XLEN-1:0]             res_data_o,
    output logic [4:0]                  res_adr_o,
    output logic                        res_v_o,
    output logic [31:0]                 pending_o,
    output logic [$clog2(DEPTH):0]      count_o
);

    localparam int unsigned PW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] mem_data [DEPTH];
    logic [4:0]      mem_adr  [DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q;
    logic [PW-1:0]   rr_ptr_q;
    logic [XLEN-1:0] last_data_q;
    logic [4:0]      last_adr_q;

    logic            accept_ok;
    logic            gnt_any;
    logic [PW-1:0]   gnt_idx;
    logic [XLEN-1:0] g_data;
    logic [4:0]      g_adr;
    logic            bypass;
    logic            push;
    logic            pop;

    // No full-pass-through: the pop happening this cycle does not free a slot for accept.
    assign accept_ok = (count_q < CW'(DEPTH));
    assign pop       = (count_q != '0);

    // Round-robin search from rr_ptr for the first valid unit; nothing is granted in reset.
    always_comb begin
        gnt_any      = 1'b0;
        gnt_idx      = '0;
        g_data       = '0;
        g_adr        = '0;
        unit_ready_o = '0;
        for (int unsigned k = 0; k < NUM_UNITS; k++) begin
            int unsigned idx;
            idx = (32'(rr_ptr_q) + k) % NUM_UNITS;
            if (!gnt_any && unit_valid_i[idx]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'(idx);
                g_data  = unit_data_i[idx*XLEN +: XLEN];
                g_adr   = unit_adr_i[idx*5 +: 5];
            end
        end
        if (rst || !accept_ok) begin
            gnt_any = 1'b0;
        end
        if (gnt_any) begin
            unit_ready_o[gnt_idx] = 1'b1;
        end
    end

    // Results to x0 are accepted but never written; bypassed results skip the FIFO.
    always_comb begin
`ifdef WB_BYPASS_EN
        bypass = gnt_any && (g_adr != 5'd0) && (count_q == '0);
`else
        bypass = 1'b0;
`endif
        push = gnt_any && (g_adr != 5'd0) && !bypass;
    end

    // Write-port outputs: FIFO head when buffered, bypassed result otherwise, else hold.
    always_comb begin
        res_v_o    = pop || bypass;
        res_data_o = last_data_q;
        res_adr_o  = last_adr_q;
        if (pop) begin
            res_data_o = mem_data[rd_ptr_q];
            res_adr_o  = mem_adr[rd_ptr_q];
        end else if (bypass) begin
            res_data_o = g_data;
            res_adr_o  = g_adr;
        end
    end

    // Pending mask: OR of one-hot destinations over the live FIFO slots.
    always_comb begin
        pending_o = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            logic [AW-1:0] off;
            off = AW'(i) - rd_ptr_q;
            if ({1'b0, off} < count_q) begin
                pending_o[mem_adr[i]] = 1'b1;
            end
        end
        pending_o[0] = 1'b0;
    end

    // FIFO storage; contents need no reset because only live slots are ever observed.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_data[wr_ptr_q] <= g_data;
            mem_adr[wr_ptr_q]  <= g_adr;
        end
    end

    // Pointers, occupancy, arbitration pointer and held output values.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            rr_ptr_q    <= '0;
            last_data_q <= '0;
            last_adr_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
            if (gnt_any) begin
                rr_ptr_q <= PW'((32'(gnt_idx) + 32'd1) % NUM_UNITS);
            end
            if (pop || bypass) begin
                last_data_q <= res_data_o;
                last_adr_q  <= res_adr_o;
            end
        end
    end

    assign count_o = count_q;

endmodule

// File: tb/tb_writeback_manager.sv
// Scoreboard bench for writeback_manager: a queue-level reference model predicts grants,
// occupancy and pending mask; accepted results go to an expected queue that a separate
// monitor pops whenever the DUT writes.
module tb_writeback_manager;

    localparam int XLEN  = 32;
    localparam int NU    = 2;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [4:0]      adr;
        logic [XLEN-1:0] data;
    } item_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NU-1:0]        unit_valid = '0;
    logic [NU-1:0]        unit_ready;
    logic [XLEN-1:0]      u_data [NU];
    logic [4:0]           u_adr  [NU];
    logic [NU*XLEN-1:0]   unit_data;
    logic [NU*5-1:0]      unit_adr;
    logic [XLEN-1:0]      res_data;
    logic [4:0]           res_adr;
    logic                 res_v;
    logic [31:0]          pending;
    logic [CW-1:0]        count;

    item_t      req_q [NU][$];
    item_t      exp_q [$];
    logic [4:0] mfifo [$];
    int         rr = 0;
    int         checks = 0;
    int         errors = 0;
    bit         gappy = 1'b0;

    always #5 clk = ~clk;

    always_comb begin
        unit_data = '0;
        unit_adr  = '0;
        for (int i = 0; i < NU; i++) begin
            unit_data[i*XLEN +: XLEN] = u_data[i];
            unit_adr[i*5 +: 5]        = u_adr[i];
        end
    end

    writeback_manager #(.XLEN(XLEN), .NUM_UNITS(NU), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .unit_valid_i (unit_valid),
        .unit_ready_o (unit_ready),
        .unit_data_i  (unit_data),
        .unit_adr_i   (unit_adr),
        .res_data_o   (res_data),
        .res_adr_o    (res_adr),
        .res_v_o      (res_v),
        .pending_o    (pending),
        .count_o      (count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver + reference model: predicts the grant from the queue-level FIFO, checks the
    // DUT state at negedge, then issues new requests just after the rising edge.
    initial begin
        int         g;
        int         idx;
        logic [NU-1:0] exp_rdy;
        logic [31:0]   pend;
        item_t         it;
        for (int u = 0; u < NU; u++) begin
            u_data[u] = '0;
            u_adr[u]  = '0;
        end
        forever begin
            @(negedge clk);
            if (!rst) begin
                g = -1;
                if (mfifo.size() < DEPTH) begin
                    for (int k = 0; k < NU; k++) begin
                        idx = (rr + k) % NU;
                        if (g < 0 && unit_valid[idx]) g = idx;
                    end
                end
                exp_rdy = '0;
                if (g >= 0) exp_rdy[g] = 1'b1;
                pend = '0;
                foreach (mfifo[i]) pend[mfifo[i]] = 1'b1;
                check("unit_ready", 64'(unit_ready), 64'(exp_rdy));
                check("count", 64'(count), 64'(mfifo.size()));
                check("res_v", 64'(res_v), 64'(mfifo.size() != 0));
                check("pending", 64'(pending), 64'(pend));
                if (mfifo.size() != 0) void'(mfifo.pop_front());
                if (g >= 0) begin
                    it = req_q[g].pop_front();
                    if (it.adr != 5'd0) begin
                        mfifo.push_back(it.adr);
                        exp_q.push_back(it);
                    end
                    rr = (g + 1) % NU;
                end
            end
            @(posedge clk);
            #1;
            if (!rst) begin
                for (int u = 0; u < NU; u++) begin
                    if (req_q[u].size() > 0 &&
                        (unit_valid[u] || !gappy || $urandom_range(0, 3) != 0)) begin
                        unit_valid[u] = 1'b1;
                        u_adr[u]      = req_q[u][0].adr;
                        u_data[u]     = req_q[u][0].data;
                    end else begin
                        unit_valid[u] = 1'b0;
                    end
                end
            end
        end
    end

    // Monitor: every write the DUT presents must match the oldest accepted result.
    initial begin
        item_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_v) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got adr %0d data %0h expected no write",
                             res_adr, res_data);
                end else begin
                    e = exp_q.pop_front();
                    check("res_adr", 64'(res_adr), 64'(e.adr));
                    check("res_data", 64'(res_data), 64'(e.data));
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst = 1'b1;
        unit_valid = '0;
        for (int u = 0; u < NU; u++) req_q[u].delete();
        exp_q.delete();
        mfifo.delete();
        rr = 0;
        @(posedge clk);
        #2;
        unit_valid = '1;
        #1;
        check("rst_ready", 64'(unit_ready), 64'd0);
        check("rst_res_v", 64'(res_v), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pending", 64'(pending), 64'd0);
        check("rst_res_adr", 64'(res_adr), 64'd0);
        check("rst_res_data", 64'(res_data), 64'd0);
        unit_valid = '0;
        rst = 1'b0;
    endtask

    task automatic push_req(input int u, input logic [4:0] adr, input logic [XLEN-1:0] data);
        item_t it;
        it.adr  = adr;
        it.data = data;
        req_q[u].push_back(it);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 300 && !done; c++) begin
            @(posedge clk);
            done = (req_q[0].size() == 0) && (req_q[1].size() == 0) &&
                   (mfifo.size() == 0) && (exp_q.size() == 0);
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d outstanding expected 0",
                     req_q[0].size() + req_q[1].size() + exp_q.size());
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        do_reset();

        // Single handshake to r5.
        push_req(0, 5'd5, 32'hDEAD_BEEF);
        wait_idle();

        // Both units continuously valid: alternating grants.
        for (int i = 0; i < 4; i++) begin
            push_req(0, 5'd1, 32'h100 + 32'(i));
            push_req(1, 5'd2, 32'h200 + 32'(i));
        end
        wait_idle();

        // x0 result is accepted and dropped.
        push_req(1, 5'd0, 32'h1234);
        wait_idle();

        // Burst of DEPTH+2 back-to-back accepts.
        for (int i = 0; i < DEPTH + 2; i++) push_req(0, 5'(3 + i), 32'hB000 + 32'(i));
        wait_idle();

        // Same destination twice.
        push_req(0, 5'd7, 32'hA);
        push_req(0, 5'd7, 32'hB);
        wait_idle();

        // Reset with results in flight: nothing buffered may be written afterwards.
        for (int i = 0; i < 6; i++) push_req(i % NU, 5'(10 + i), 32'hC000 + 32'(i));
        for (int c = 0; c < 20 && mfifo.size() == 0; c++) @(posedge clk);
        do_reset();
        repeat (4) @(posedge clk);

        // Randomized traffic with gaps and occasional x0 destinations.
        gappy = 1'b1;
        for (int r = 0; r < 6; r++) begin
            for (int u = 0; u < NU; u++) begin
                int n;
                n = $urandom_range(0, 10);
                for (int i = 0; i < n; i++) begin
                    push_req(u, ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                             $urandom);
                end
            end
            wait_idle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
